// File: rtl/v_row_loader_pkg.sv
// Shared types for the V-row loader: the assembled row vector and the FSM state enum.
// MAX_SEQ_LENGTH may be supplied by the build; it falls back to 8 rows.
`ifndef MAX_SEQ_LENGTH
`define MAX_SEQ_LENGTH 8
`endif

package v_row_loader_pkg;
  localparam int V_VEC_W = 512;
  typedef logic [V_VEC_W-1:0] V_VECTOR_T;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RSP,
    ST_PUSH,
    ST_FIN
  } v_loader_state_t;

  // Counter width that stays legal when the count is 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/v_row_loader_beat_packer.sv
// v_beat_packer: gathers MEM_DATA_W beats into one V_VECTOR_T, beat 0 in the LSBs.
module v_beat_packer
  import v_row_loader_pkg::*;
#(
  parameter int MEM_DATA_W = 64,
  parameter int BEATS      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  beat_valid_i,
  input  logic [MEM_DATA_W-1:0] beat_data_i,
  output logic                  row_full_o,
  output V_VECTOR_T             row_o
);
  localparam int BW = cnt_w(BEATS);

  logic [BW-1:0] beat_q;
  V_VECTOR_T     row_q;

  // High in the cycle the final beat of a row is captured.
  assign row_full_o = beat_valid_i && (beat_q == BW'(BEATS - 1));
  assign row_o      = row_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q <= '0;
      row_q  <= '0;
    end else if (clear_i) begin
      beat_q <= '0;
    end else if (beat_valid_i) begin
      row_q[beat_q*MEM_DATA_W +: MEM_DATA_W] <= beat_data_i;
      beat_q <= row_full_o ? '0 : beat_q + BW'(1);
    end
  end
endmodule

// File: rtl/v_row_loader.sv
// v_row_loader: fetches V rows beat by beat, assembles them and pushes each row into the V FIFO.
// Define V_LOADER_STATS_EN to count FIFO back-pressure cycles on stall_cycles.
module v_row_loader
  import v_row_loader_pkg::*;
#(
  parameter int MEM_DATA_W = 64,
  parameter int ADDR_W     = 32,
  parameter int MAX_ROWS   = `MAX_SEQ_LENGTH,
  localparam int NR_W      = $clog2(MAX_ROWS) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [NR_W-1:0]       num_rows,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [MEM_DATA_W-1:0] mem_rsp_data,
  output logic                  write_enable,
  input  logic                  sram_ready,
  output V_VECTOR_T             write_data,
  output logic [31:0]           stall_cycles
);
  localparam int BEATS = $bits(V_VECTOR_T) / MEM_DATA_W;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(MEM_DATA_W / 8);

  if (BEATS < 1 || BEATS * MEM_DATA_W != $bits(V_VECTOR_T)) begin : g_bad_width
    $error("v_row_loader: V_VECTOR_T width is not a whole number of MEM_DATA_W beats");
  end

  v_loader_state_t state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [NR_W-1:0]   rows_q, row_cnt_q, rows_d;
  logic              busy_q, done_q, req_valid_q, we_q;
  logic              start_ok, beat_valid, row_full;

  assign start_ok   = (state_q == ST_IDLE) && start;
  assign beat_valid = (state_q == ST_RSP) && mem_rsp_valid;
  assign rows_d     = (num_rows > NR_W'(MAX_ROWS)) ? NR_W'(MAX_ROWS) : num_rows;

  v_beat_packer #(.MEM_DATA_W(MEM_DATA_W), .BEATS(BEATS)) u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (start_ok),
    .beat_valid_i (beat_valid),
    .beat_data_i  (mem_rsp_data),
    .row_full_o   (row_full),
    .row_o        (write_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rows_q      <= '0;
      row_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      req_valid_q <= 1'b0;
      we_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          addr_q    <= base_addr;
          rows_q    <= rows_d;
          row_cnt_q <= '0;
          if (rows_d == '0) begin
            state_q <= ST_FIN;
            done_q  <= 1'b1;
          end else begin
            state_q     <= ST_REQ;
            busy_q      <= 1'b1;
            req_valid_q <= 1'b1;
          end
        end
        ST_REQ: if (mem_req_ready) begin
          addr_q      <= addr_q + STEP;
          req_valid_q <= 1'b0;
          state_q     <= ST_RSP;
        end
        ST_RSP: if (mem_rsp_valid) begin
          if (row_full) begin
            state_q <= ST_PUSH;
            we_q    <= 1'b1;
          end else begin
            state_q     <= ST_REQ;
            req_valid_q <= 1'b1;
          end
        end
        ST_PUSH: if (sram_ready) begin
          we_q      <= 1'b0;
          row_cnt_q <= row_cnt_q + NR_W'(1);
          if (row_cnt_q + NR_W'(1) == rows_q) begin
            state_q <= ST_FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q     <= ST_REQ;
            req_valid_q <= 1'b1;
          end
        end
        ST_FIN: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = addr_q;
  assign write_enable  = we_q;

`ifdef V_LOADER_STATS_EN
  logic [31:0] stall_q;
  // Saturating count of PUSH cycles refused by the FIFO.
  always_ff @(posedge clk) begin
    if (rst || start_ok)
      stall_q <= '0;
    else if (state_q == ST_PUSH && !sram_ready && stall_q != 32'hFFFF_FFFF)
      stall_q <= stall_q + 32'd1;
  end
  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_v_row_loader.sv
// Directed bench for v_row_loader: memory/FIFO responders on the falling edge, checks via chk().
`timescale 1ns/1ps
module tb_v_row_loader;
  import v_row_loader_pkg::*;

  localparam int MAXR = 8;
  localparam int NR_W = $clog2(MAXR) + 1;

  logic            clk = 0, rst = 1, start = 0;
  logic [31:0]     base_addr = '0;
  logic [NR_W-1:0] num_rows = '0;
  logic            busy, done, mem_req_valid, mem_req_ready = 0;
  logic [31:0]     mem_req_addr;
  logic            mem_rsp_valid = 0;
  logic [63:0]     mem_rsp_data = '0;
  logic            write_enable, sram_ready = 1;
  V_VECTOR_T       write_data;
  logic [31:0]     stall_cycles;

  v_row_loader #(.MEM_DATA_W(64), .ADDR_W(32), .MAX_ROWS(MAXR)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_rows(num_rows),
    .busy(busy), .done(done), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .write_enable(write_enable), .sram_ready(sram_ready), .write_data(write_data),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] beat_fn(input logic [31:0] a);
    return {a ^ 32'hDEADBEEF, a};
  endfunction

  function automatic V_VECTOR_T exp_row(input logic [31:0] base, input int r);
    V_VECTOR_T v;
    for (int b = 0; b < 8; b++) v[b*64 +: 64] = beat_fn(base + 32'((r*8 + b)*8));
    return v;
  endfunction

  // Model state shared between the responder and the stimulus.
  logic [31:0] req_q[$];
  V_VECTOR_T   wr_q[$];
  int req_stall = 0, rsp_delay = 0, stall_left = 0, done_cnt = 0;
  int req_wait = 0, rsp_wait = 0;
  bit rsp_pend = 0, req_held = 0, stalling = 0;
  logic [31:0] rsp_addr, held_addr;
  V_VECTOR_T held_data;

  always @(negedge clk) begin
    if (rst) begin
      mem_rsp_valid = 0; mem_req_ready = 0; sram_ready = 1;
      rsp_pend = 0; req_held = 0; stalling = 0; req_wait = 0;
    end else begin
      mem_rsp_valid = 0;
      if (rsp_pend) begin
        if (rsp_wait == 0) begin
          mem_rsp_valid = 1; mem_rsp_data = beat_fn(rsp_addr); rsp_pend = 0;
        end else rsp_wait--;
      end
      mem_req_ready = 0;
      if (mem_req_valid) begin
        if (req_held) chk("addr_hold", 512'(mem_req_addr), 512'(held_addr));
        if (req_wait < req_stall) begin
          req_wait++; req_held = 1; held_addr = mem_req_addr;
        end else begin
          mem_req_ready = 1; req_q.push_back(mem_req_addr);
          rsp_pend = 1; rsp_wait = rsp_delay; rsp_addr = mem_req_addr;
          req_wait = 0; req_held = 0;
        end
      end
      if (write_enable) begin
        chk("no_req_in_push", 512'(mem_req_valid), 512'(0));
        if (stalling) chk("data_hold", write_data, held_data);
        if (stall_left > 0) begin
          sram_ready = 0; stall_left--; stalling = 1; held_data = write_data;
        end else begin
          sram_ready = 1; stalling = 0; wr_q.push_back(write_data);
        end
      end else sram_ready = 1;
      if (done) begin
        done_cnt++;
        chk("busy_at_done", 512'(busy), 512'(0));
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic pulse_start(input logic [31:0] b, input int n);
    start = 1; base_addr = b; num_rows = NR_W'(n);
    tick();
    start = 0;
  endtask

  task automatic run_job(input logic [31:0] b, input int n, input int rows,
                         input int rs, input int rd, input int ss, input bit poke);
    int i;
    req_q.delete(); wr_q.delete(); done_cnt = 0;
    req_stall = rs; rsp_delay = rd; stall_left = ss;
    pulse_start(b, n);
    for (i = 0; i < 20000 && done_cnt == 0; i++) begin
      if (poke && i == 10) begin
        start = 1; base_addr = 32'hBAD0; num_rows = NR_W'(1);
        tick();
        start = 0;
      end else tick();
    end
    chk("timeout", 512'(done_cnt > 0), 512'(1));
    repeat (3) tick();
    chk("done_once", 512'(done_cnt), 512'(1));
    chk("req_count", 512'(req_q.size()), 512'(rows*8));
    for (int k = 0; k < req_q.size() && k < rows*8; k++)
      chk($sformatf("req_addr%0d", k), 512'(req_q[k]), 512'(b + 32'(k*8)));
    chk("row_count", 512'(wr_q.size()), 512'(rows));
    for (int r = 0; r < wr_q.size() && r < rows; r++)
      chk($sformatf("row%0d", r), wr_q[r], exp_row(b, r));
  endtask

  initial begin
    int i;
    repeat (3) tick();
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_done", 512'(done), 512'(0));
    chk("rst_req", 512'(mem_req_valid), 512'(0));
    chk("rst_we", 512'(write_enable), 512'(0));
    chk("rst_data", write_data, 512'(0));
    chk("rst_stall", 512'(stall_cycles), 512'(0));
    rst = 0;
    tick();

    // Basic two-row job, plus hand-computed beats at both ends.
    run_job(32'h1000, 2, 2, 0, 0, 0, 0);
    chk("row0_beat0", 512'(wr_q[0][63:0]), 512'(64'hDEADAEEF_00001000));
    chk("row1_beat7", 512'(wr_q[1][511:448]), 512'(64'hDEADAE97_00001078));
    chk("stall_none", 512'(stall_cycles), 512'(0));

    // FIFO back-pressure for 5 cycles on the first row.
    run_job(32'h2000, 2, 2, 0, 0, 5, 0);
`ifdef V_LOADER_STATS_EN
    chk("stall_five", 512'(stall_cycles), 512'(5));
`else
    chk("stall_tied", 512'(stall_cycles), 512'(0));
`endif

    // Memory stalls; stall counter clears on the new start.
    run_job(32'h1000, 2, 2, 3, 4, 0, 0);
    chk("stall_clr", 512'(stall_cycles), 512'(0));

    // Zero rows: done the cycle after start, no requests.
    req_q.delete(); done_cnt = 0;
    pulse_start(32'h5000, 0);
    chk("zero_done", 512'(done), 512'(1));
    chk("zero_busy", 512'(busy), 512'(0));
    repeat (3) tick();
    chk("zero_reqs", 512'(req_q.size()), 512'(0));
    chk("zero_done_once", 512'(done_cnt), 512'(1));

    // Clamp, and a start while busy that must be ignored.
    run_job(32'h8000, MAXR + 5, MAXR, 0, 0, 0, 0);
    run_job(32'h4000, 2, 2, 0, 0, 0, 1);

    // Reset in the middle of a response wait.
    req_q.delete(); done_cnt = 0; rsp_delay = 4; req_stall = 0; stall_left = 0;
    pulse_start(32'h3000, 2);
    for (i = 0; i < 500 && req_q.size() < 3; i++) tick();
    chk("mid_timeout", 512'(req_q.size()), 512'(3));
    tick();
    rst = 1;
    tick();
    chk("mid_busy", 512'(busy), 512'(0));
    chk("mid_done", 512'(done), 512'(0));
    chk("mid_req", 512'(mem_req_valid), 512'(0));
    chk("mid_we", 512'(write_enable), 512'(0));
    chk("mid_data", write_data, 512'(0));
    rst = 0;
    repeat (6) tick();
    chk("mid_no_done", 512'(done_cnt), 512'(0));
    run_job(32'h3000, 2, 2, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
